// File: rtl/gate_seq_pkg.sv
// Shared types and the gate-bank truth table for the gate bank sequencer.
// The expected() function defines the reference output vector per input pair.
package gate_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int Y_XOR = 0;
    localparam int Y_NOT = 1;
    localparam int Y_AND = 2;
    localparam int Y_OR  = 3;

    function automatic logic [3:0] expected(input logic x0, input logic x1);
        logic [3:0] y;
        y        = '0;
        y[Y_XOR] = x0 ^ x1;
        y[Y_NOT] = ~x0;
        y[Y_AND] = x0 & x1;
        y[Y_OR]  = x0 | x1;
        return y;
    endfunction

endpackage

// File: rtl/gate_bank_sequencer_btn.sv
// Push-button conditioner: 2-flop synchroniser, plus a stable-count
// filter when GATE_SEQ_DEBOUNCE_EN is defined.
module btn_conditioner
`ifdef GATE_SEQ_DEBOUNCE_EN
#(
    parameter int DB_CYCLES = 1000
)
`endif
(
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic btn_o
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], btn};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

`ifdef GATE_SEQ_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          stable_q;
    logic          stable_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Accept a new level only after DB_CYCLES consecutive differing samples.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_q[1] != stable_q) begin
            if (cnt_q == CW'(DB_CYCLES - 1)) begin
                stable_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign btn_o = stable_q;
`else
    assign btn_o = sync_q[1];
`endif

endmodule

// File: rtl/gate_bank_sequencer.sv
// Gate bank sequencer: manual or swept drive of x0/x1 with self-check.
// Define GATE_SEQ_DEBOUNCE_EN to add a debounce filter on the buttons.
module gate_bank_sequencer
    import gate_seq_pkg::*;
#(
    parameter int DWELL_W   = 16,
    parameter int DB_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               auto_loop,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               btn_a,
    input  logic               btn_b,
    output logic               gate_x0,
    output logic               gate_x1,
    input  logic [3:0]         gate_y,
    output logic [3:0]         led,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [3:0]         err_vec
);

    logic btn_a_c;
    logic btn_b_c;

`ifdef GATE_SEQ_DEBOUNCE_EN
    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_btn_a (
`else
    btn_conditioner u_btn_a (
`endif
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_a),
        .btn_o (btn_a_c)
    );

`ifdef GATE_SEQ_DEBOUNCE_EN
    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_btn_b (
`else
    btn_conditioner u_btn_b (
`endif
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_b),
        .btn_o (btn_b_c)
    );

    state_t             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dw_q, dw_d;
    logic               x0_q, x0_d;
    logic               x1_q, x1_d;
    logic [3:0]         led_q, led_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [3:0]         err_q, err_d;
    logic [3:0]         mism;
    logic [DWELL_W-1:0] dw_eff;

    assign dw_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
    assign mism   = gate_y ^ expected(idx_q[0], idx_q[1]);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        dw_d    = dw_q;
        x0_d    = x0_q;
        x1_d    = x1_q;
        led_d   = gate_y;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                x0_d = btn_a_c;
                x1_d = btn_b_c;
                if (start) begin
                    state_d = HOLD;
                    idx_d   = '0;
                    cnt_d   = '0;
                    dw_d    = dw_eff;
                    err_d   = '0;
                    x0_d    = 1'b0;
                    x1_d    = 1'b0;
                end
            end
            HOLD: begin
                cnt_d = cnt_q + DWELL_W'(1);
                if (cnt_q == dw_q - DWELL_W'(1)) begin
                    err_d = err_q | mism;
                    cnt_d = '0;
                    if (idx_q == 2'd3) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        idx_d        = idx_q + 2'd1;
                        {x1_d, x0_d} = idx_q + 2'd1;
                    end
                end
            end
            DONE: begin
                if (auto_loop) begin
                    state_d = HOLD;
                    idx_d   = '0;
                    cnt_d   = '0;
                    dw_d    = dw_eff;
                    err_d   = '0;
                    x0_d    = 1'b0;
                    x1_d    = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            dw_q    <= DWELL_W'(1);
            x0_q    <= 1'b0;
            x1_q    <= 1'b0;
            led_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            dw_q    <= dw_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            led_q   <= led_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
        end
    end

    assign gate_x0 = x0_q;
    assign gate_x1 = x1_q;
    assign led     = led_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign pass    = pass_q;
    assign err_vec = err_q;

endmodule

// File: tb/tb_gate_bank_sequencer.sv
// Directed bench for gate_bank_sequencer with a behavioural gate bank
// that supports stuck-at-0 and inversion faults per output bit.
module tb_gate_bank_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        auto_loop;
    logic [15:0] dwell;
    logic        btn_a;
    logic        btn_b;
    logic        gate_x0;
    logic        gate_x1;
    logic [3:0]  gate_y;
    logic [3:0]  led;
    logic        busy;
    logic        done;
    logic        pass;
    logic [3:0]  err_vec;
    logic [3:0]  stuck0;
    logic [3:0]  flip;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        gate_y = ({gate_x0 | gate_x1, gate_x0 & gate_x1, ~gate_x0,
                   gate_x0 ^ gate_x1} & ~stuck0) ^ flip;
    end

    gate_bank_sequencer #(
        .DWELL_W   (16),
        .DB_CYCLES (20)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .auto_loop (auto_loop),
        .dwell     (dwell),
        .btn_a     (btn_a),
        .btn_b     (btn_b),
        .gate_x0   (gate_x0),
        .gate_x1   (gate_x1),
        .gate_y    (gate_y),
        .led       (led),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_vec   (err_vec)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        start     = 1'($urandom);
        auto_loop = 1'($urandom);
        dwell     = 16'($urandom);
        btn_a     = 1'($urandom);
        btn_b     = 1'($urandom);
        stuck0    = '0;
        flip      = '0;
        repeat (3) tick();
        checks++;
        if ({gate_x1, gate_x0, led, busy, done, pass, err_vec} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0",
                     {gate_x1, gate_x0, led, busy, done, pass, err_vec});
        end
        start     = 1'b0;
        auto_loop = 1'b0;
        btn_a     = 1'b0;
        btn_b     = 1'b0;
        dwell     = 16'd3;
        rst_n     = 1'b1;
        repeat (4) tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_good_sweep();
        logic [3:0] led_tab [4];
        led_tab = '{4'b0010, 4'b1001, 4'b1011, 4'b1100};
        dwell = 16'd3;
        pulse_start();
        for (int i = 1; i <= 15; i++) begin
            if (i <= 12) begin
                checks++;
                if ({gate_x1, gate_x0} !== 2'((i - 1) / 3)) begin
                    errors++;
                    $display("FAIL good_vec cyc=%0d got %b want %0d",
                             i, {gate_x1, gate_x0}, (i - 1) / 3);
                end
            end
            checks++;
            if (done !== (i == 13)) begin
                errors++;
                $display("FAIL good_done cyc=%0d got %b", i, done);
            end
            checks++;
            if (busy !== (i <= 13)) begin
                errors++;
                $display("FAIL good_busy cyc=%0d got %b", i, busy);
            end
            if (i == 2 || i == 5 || i == 8 || i == 11) begin
                checks++;
                if (led !== led_tab[(i - 2) / 3]) begin
                    errors++;
                    $display("FAIL good_led cyc=%0d got %b want %b",
                             i, led, led_tab[(i - 2) / 3]);
                end
            end
            if (i == 13) begin
                checks++;
                if (pass !== 1'b1 || err_vec !== 4'b0000) begin
                    errors++;
                    $display("FAIL good_result pass=%b err=%b want 1 0000",
                             pass, err_vec);
                end
            end
            tick();
        end
    endtask

    task automatic test_faulty_and();
        stuck0 = 4'b0100;
        dwell  = 16'd2;
        pulse_start();
        for (int i = 1; i <= 11; i++) begin
            checks++;
            if (done !== (i == 9)) begin
                errors++;
                $display("FAIL and_done cyc=%0d got %b", i, done);
            end
            if (i == 9) begin
                checks++;
                if (pass !== 1'b0 || err_vec !== 4'b0100) begin
                    errors++;
                    $display("FAIL and_result pass=%b err=%b want 0 0100",
                             pass, err_vec);
                end
            end
            tick();
        end
        stuck0 = '0;
    endtask

    task automatic test_dwell_zero();
        int ndone;
        ndone = 0;
        dwell = 16'd0;
        pulse_start();
        for (int i = 1; i <= 12; i++) begin
            start = (i == 2);
            checks++;
            if (done !== (i == 5)) begin
                errors++;
                $display("FAIL d0_done cyc=%0d got %b", i, done);
            end
            if (done === 1'b1) ndone++;
            if (i == 5) begin
                checks++;
                if (pass !== 1'b1) begin
                    errors++;
                    $display("FAIL d0_pass got %b want 1", pass);
                end
            end
            tick();
        end
        start = 1'b0;
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL d0_count got %0d want 1", ndone);
        end
    endtask

    task automatic test_auto_loop();
        dwell     = 16'd1;
        auto_loop = 1'b1;
        pulse_start();
        for (int i = 1; i <= 17; i++) begin
            flip = (i >= 6 && i <= 9) ? 4'b0001 : 4'b0000;
            if (i == 11) auto_loop = 1'b0;
            checks++;
            if (done !== (i == 5 || i == 10 || i == 15)) begin
                errors++;
                $display("FAIL loop_done cyc=%0d got %b", i, done);
            end
            if (i == 5 || i == 15) begin
                checks++;
                if (pass !== 1'b1 || err_vec !== 4'b0000) begin
                    errors++;
                    $display("FAIL loop_good cyc=%0d pass=%b err=%b want 1 0000",
                             i, pass, err_vec);
                end
            end
            if (i == 10) begin
                checks++;
                if (pass !== 1'b0 || err_vec !== 4'b0001) begin
                    errors++;
                    $display("FAIL loop_bad pass=%b err=%b want 0 0001",
                             pass, err_vec);
                end
            end
            if (i == 11 || i == 16) begin
                checks++;
                if (busy !== (i == 11) || (i == 11 && err_vec !== 4'b0000)) begin
                    errors++;
                    $display("FAIL loop_state cyc=%0d busy=%b err=%b",
                             i, busy, err_vec);
                end
            end
            tick();
        end
        flip = '0;
    endtask

    task automatic test_reset_mid();
        int ndone;
        ndone = 0;
        dwell = 16'd2;
        pulse_start();
        repeat (3) tick();
        checks++;
        if (gate_x0 !== 1'b1 || pass !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre x0=%b pass=%b want 1 1", gate_x0, pass);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gate_x1, gate_x0, led, busy, done, pass, err_vec} !== 15'd0) begin
            errors++;
            $display("FAIL mid_reset got %b want 0",
                     {gate_x1, gate_x0, led, busy, done, pass, err_vec});
        end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (done === 1'b1) ndone++;
            tick();
        end
        checks++;
        if (ndone != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_nodone dones=%0d busy=%b want 0 0", ndone, busy);
        end
    endtask

`ifdef GATE_SEQ_DEBOUNCE_EN
    task automatic test_debounce();
        int seen;
        seen  = 0;
        btn_a = 1'b1;
        repeat (10) tick();
        btn_a = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (gate_x0 !== 1'b0) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL db_glitch high_cycles=%0d want 0", seen);
        end
        btn_a = 1'b1;
        repeat (25) tick();
        checks++;
        if (gate_x0 !== 1'b1) begin
            errors++;
            $display("FAIL db_press got %b want 1", gate_x0);
        end
        btn_a = 1'b0;
        repeat (30) tick();
    endtask
`else
    task automatic test_manual();
        btn_a = 1'b1;
        repeat (2) tick();
        checks++;
        if (gate_x0 !== 1'b0) begin
            errors++;
            $display("FAIL man_early got %b want 0", gate_x0);
        end
        tick();
        checks++;
        if (gate_x0 !== 1'b1 || gate_x1 !== 1'b0) begin
            errors++;
            $display("FAIL man_a x0=%b x1=%b want 1 0", gate_x0, gate_x1);
        end
        btn_b = 1'b1;
        repeat (3) tick();
        checks++;
        if (gate_x1 !== 1'b1) begin
            errors++;
            $display("FAIL man_b got %b want 1", gate_x1);
        end
        btn_a = 1'b0;
        btn_b = 1'b0;
        repeat (4) tick();
        checks++;
        if ({gate_x1, gate_x0} !== 2'b00) begin
            errors++;
            $display("FAIL man_release got %b want 00", {gate_x1, gate_x0});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_good_sweep();
        test_faulty_and();
        test_dwell_zero();
        test_auto_loop();
        test_reset_mid();
`ifdef GATE_SEQ_DEBOUNCE_EN
        test_debounce();
`else
        test_manual();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
